// File: rtl/cmd_proc.sv
// cmd_proc: executes one 16-bit command at a time from the UART wrapper
// (calibrate or square-counted move) and returns a one-byte response.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   cmd, cmd_rdy  command word and its ready level from the wrapper
//   clr_cmd_rdy   one-cycle pulse: command accepted
//   trmt, resp    one-cycle transmit strobe and the response byte
//   tx_done       wrapper transmit-complete level
//   strt_cal      one-cycle pulse: start calibration
//   cal_done      calibration complete
//   cntrIR        asynchronous line-crossing sensor
//   moving        high while a move executes
//   dsrd_hdg      desired heading of the last MOVE
module cmd_proc #(
  parameter logic [23:0] MOVE_TMO = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        trmt,
  output logic [7:0]  resp,
  input  logic        tx_done,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic        cntrIR,
  output logic        moving,
  output logic [7:0]  dsrd_hdg
);

  localparam int unsigned LINE_W = 5;
  localparam int unsigned TMO_W  = 24;
  localparam logic [3:0]  OP_CAL   = 4'h2;
  localparam logic [3:0]  OP_MOVE  = 4'h4;
  localparam logic [7:0]  RESP_ACK = 8'hA5;
  localparam logic [7:0]  RESP_ERR = 8'hEE;
  localparam logic [TMO_W-1:0] TMO_LAST = MOVE_TMO - TMO_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAL_WAIT = 3'd1,
    MOVING   = 3'd2,
    RESP     = 3'd3,
    WAIT_TX  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [LINE_W-1:0] line_cnt, line_cnt_nxt, line_tgt, line_tgt_nxt, cnt_inc;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic              resp_pend, resp_pend_nxt;
  logic              clr_nxt, trmt_nxt, strt_nxt, moving_nxt;
  logic [7:0]        resp_nxt, hdg_nxt;
  logic              ir_s1, ir_s2, ir_s3, ir_rise;
  logic              accept, is_cal, is_move, sq_zero, mv_done, mv_tmo;

  // Command decode; a pending immediate response blocks re-acceptance while
  // the wrapper still holds cmd_rdy.
  assign is_cal  = (cmd[15:12] == OP_CAL);
  assign is_move = (cmd[15:12] == OP_MOVE);
  assign sq_zero = (cmd[3:0] == 4'h0);
  assign accept  = (state == IDLE) && cmd_rdy && !resp_pend;

  // Line-crossing synchronizer and rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_s1 <= 1'b0;
      ir_s2 <= 1'b0;
      ir_s3 <= 1'b0;
    end else begin
      ir_s1 <= cntrIR;
      ir_s2 <= ir_s1;
      ir_s3 <= ir_s2;
    end
  end

  assign ir_rise = ir_s2 & ~ir_s3;
  assign cnt_inc = line_cnt + LINE_W'(ir_rise);
  assign mv_done = (cnt_inc == line_tgt);
  assign mv_tmo  = (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (resp_pend)
          state_nxt = RESP;
        else if (accept && is_cal)
          state_nxt = CAL_WAIT;
        else if (accept && is_move && !sq_zero)
          state_nxt = MOVING;
      end
      CAL_WAIT: if (cal_done)          state_nxt = RESP;
      MOVING:   if (mv_done || mv_tmo) state_nxt = RESP;
      RESP:     state_nxt = WAIT_TX;
      WAIT_TX:  if (tx_done)           state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    clr_nxt       = accept;
    strt_nxt      = accept && is_cal;
    trmt_nxt      = (state_nxt == RESP);
    moving_nxt    = moving;
    resp_nxt      = resp;
    hdg_nxt       = dsrd_hdg;
    line_tgt_nxt  = line_tgt;
    line_cnt_nxt  = line_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    resp_pend_nxt = 1'b0;

    if (accept) begin
      tmo_cnt_nxt  = '0;
      line_cnt_nxt = '0;
      if (is_move) begin
        hdg_nxt      = cmd[11:4];
        line_tgt_nxt = {cmd[3:0], 1'b0};
        if (!sq_zero) moving_nxt = 1'b1;
      end
      // Zero-square MOVE and illegal opcodes answer immediately
      if (!is_cal && !(is_move && !sq_zero)) begin
        resp_pend_nxt = 1'b1;
        resp_nxt      = is_move ? RESP_ACK : RESP_ERR;
      end
    end

    if (state == CAL_WAIT && cal_done) resp_nxt = RESP_ACK;

    if (state == MOVING) begin
      line_cnt_nxt = cnt_inc;
      tmo_cnt_nxt  = tmo_cnt + TMO_W'(1);
      if (mv_done || mv_tmo) begin
        moving_nxt = 1'b0;
        // Completion takes priority over a coincident timeout
        resp_nxt   = mv_done ? RESP_ACK : RESP_ERR;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cmd_rdy <= 1'b0;
      trmt        <= 1'b0;
      strt_cal    <= 1'b0;
      moving      <= 1'b0;
      resp        <= 8'h00;
      dsrd_hdg    <= 8'h00;
      line_tgt    <= '0;
      line_cnt    <= '0;
      tmo_cnt     <= '0;
      resp_pend   <= 1'b0;
    end else begin
      clr_cmd_rdy <= clr_nxt;
      trmt        <= trmt_nxt;
      strt_cal    <= strt_nxt;
      moving      <= moving_nxt;
      resp        <= resp_nxt;
      dsrd_hdg    <= hdg_nxt;
      line_tgt    <= line_tgt_nxt;
      line_cnt    <= line_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      resp_pend   <= resp_pend_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: calibration, move, timeout, illegal and
// zero-square commands, back-to-back commands and reset during a move.
module tb_cmd_proc;

  logic        clk, rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, trmt, tx_done, strt_cal, cal_done;
  logic        cntrIR, moving;
  logic [7:0]  resp, dsrd_hdg;

  int vecs = 0;
  int errs = 0;

  cmd_proc #(.MOVE_TMO(24'd1000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done),
    .strt_cal(strt_cal), .cal_done(cal_done), .cntrIR(cntrIR),
    .moving(moving), .dsrd_hdg(dsrd_hdg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ir_pulse();
    cntrIR = 1'b1;
    tick(); tick();
    cntrIR = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic release_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd = 16'h0; cmd_rdy = 0; tx_done = 0; cal_done = 0; cntrIR = 0;
    tick(); tick();
    vecs++;
    if ({clr_cmd_rdy, trmt, strt_cal, moving, resp, dsrd_hdg} !== 20'h0) begin
      errs++;
      $display("FAIL reset_outputs got clr=%b trmt=%b strt=%b mov=%b resp=%h hdg=%h want all 0",
               clr_cmd_rdy, trmt, strt_cal, moving, resp, dsrd_hdg);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cal();
    int pulses;
    cmd = 16'h2000; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    vecs++;
    if (!(clr_cmd_rdy === 1'b1 && strt_cal === 1'b1 && moving === 1'b0 && trmt === 1'b0)) begin
      errs++;
      $display("FAIL cal_accept got clr=%b strt=%b mov=%b trmt=%b want 1 1 0 0",
               clr_cmd_rdy, strt_cal, moving, trmt);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      pulses += int'(clr_cmd_rdy) + int'(strt_cal) + int'(trmt);
    end
    vecs++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL cal_wait_quiet got %0d extra pulses want 0", pulses);
    end
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    vecs++;
    if (!(trmt === 1'b1 && resp === 8'hA5)) begin
      errs++;
      $display("FAIL cal_resp got trmt=%b resp=%h want 1 a5", trmt, resp);
    end
    tick();
    vecs++;
    if (trmt !== 1'b0) begin
      errs++;
      $display("FAIL cal_trmt_pulse got trmt=%b want 0", trmt);
    end
    tick(); tick();
    release_tx();
  endtask

  task automatic test_move();
    cmd = 16'h43F2; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    vecs++;
    if (!(moving === 1'b1 && clr_cmd_rdy === 1'b1 && dsrd_hdg === 8'h3F && strt_cal === 1'b0)) begin
      errs++;
      $display("FAIL move_accept got mov=%b clr=%b hdg=%h strt=%b want 1 1 3f 0",
               moving, clr_cmd_rdy, dsrd_hdg, strt_cal);
    end
    ir_pulse(); ir_pulse(); ir_pulse();
    vecs++;
    if (!(moving === 1'b1 && trmt === 1'b0)) begin
      errs++;
      $display("FAIL move_3_lines got mov=%b trmt=%b want 1 0", moving, trmt);
    end
    cntrIR = 1'b1;
    tick(); tick();
    vecs++;
    if (moving !== 1'b1) begin
      errs++;
      $display("FAIL move_2clk_after_edge got mov=%b want 1", moving);
    end
    tick();
    cntrIR = 1'b0;
    vecs++;
    if (!(moving === 1'b0 && trmt === 1'b1 && resp === 8'hA5)) begin
      errs++;
      $display("FAIL move_done got mov=%b trmt=%b resp=%h want 0 1 a5", moving, trmt, resp);
    end
    tick();
    release_tx();
  endtask

  task automatic test_timeout();
    int n;
    cmd = 16'h4013; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    vecs++;
    if (!(moving === 1'b1 && dsrd_hdg === 8'h01)) begin
      errs++;
      $display("FAIL tmo_accept got mov=%b hdg=%h want 1 01", moving, dsrd_hdg);
    end
    ir_pulse(); ir_pulse();
    n = 10;
    while (moving === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    vecs++;
    if (n != 1000) begin
      errs++;
      $display("FAIL tmo_cycles got %0d moving cycles want 1000", n);
    end
    vecs++;
    if (!(trmt === 1'b1 && resp === 8'hEE)) begin
      errs++;
      $display("FAIL tmo_resp got trmt=%b resp=%h want 1 ee", trmt, resp);
    end
    tick();
    release_tx();
  endtask

  task automatic test_illegal_zero();
    cmd = 16'h7000; cmd_rdy = 1'b1;
    tick();
    vecs++;
    if (!(clr_cmd_rdy === 1'b1 && trmt === 1'b0 && moving === 1'b0 && strt_cal === 1'b0)) begin
      errs++;
      $display("FAIL ill_accept got clr=%b trmt=%b mov=%b strt=%b want 1 0 0 0",
               clr_cmd_rdy, trmt, moving, strt_cal);
    end
    tick();
    cmd_rdy = 1'b0;
    vecs++;
    if (!(trmt === 1'b1 && resp === 8'hEE && clr_cmd_rdy === 1'b0 && dsrd_hdg === 8'h01 &&
          moving === 1'b0 && strt_cal === 1'b0)) begin
      errs++;
      $display("FAIL ill_resp got trmt=%b resp=%h clr=%b hdg=%h mov=%b strt=%b want 1 ee 0 01 0 0",
               trmt, resp, clr_cmd_rdy, dsrd_hdg, moving, strt_cal);
    end
    tick();
    release_tx();

    cmd = 16'h4550; cmd_rdy = 1'b1;
    tick();
    vecs++;
    if (!(clr_cmd_rdy === 1'b1 && moving === 1'b0 && dsrd_hdg === 8'h55 && trmt === 1'b0)) begin
      errs++;
      $display("FAIL zero_accept got clr=%b mov=%b hdg=%h trmt=%b want 1 0 55 0",
               clr_cmd_rdy, moving, dsrd_hdg, trmt);
    end
    tick();
    cmd_rdy = 1'b0;
    vecs++;
    if (!(trmt === 1'b1 && resp === 8'hA5 && moving === 1'b0)) begin
      errs++;
      $display("FAIL zero_resp got trmt=%b resp=%h mov=%b want 1 a5 0", trmt, resp, moving);
    end
    tick();
    release_tx();
  endtask

  task automatic test_back_to_back();
    int clrs;
    cmd = 16'h7000; cmd_rdy = 1'b1;
    tick(); tick();
    cmd_rdy = 1'b0;
    tick();
    cmd = 16'h4550; cmd_rdy = 1'b1;
    clrs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      clrs += int'(clr_cmd_rdy);
    end
    vecs++;
    if (clrs != 0) begin
      errs++;
      $display("FAIL b2b_blocked got %0d clr pulses want 0", clrs);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    vecs++;
    if (clr_cmd_rdy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_txdone_edge got clr=%b want 0", clr_cmd_rdy);
    end
    tick();
    vecs++;
    if (!(clr_cmd_rdy === 1'b1 && dsrd_hdg === 8'h55)) begin
      errs++;
      $display("FAIL b2b_accept got clr=%b hdg=%h want 1 55", clr_cmd_rdy, dsrd_hdg);
    end
    clrs = 0;
    tick();
    clrs += int'(clr_cmd_rdy);
    cmd_rdy = 1'b0;
    vecs++;
    if (!(trmt === 1'b1 && resp === 8'hA5)) begin
      errs++;
      $display("FAIL b2b_resp got trmt=%b resp=%h want 1 a5", trmt, resp);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      clrs += int'(clr_cmd_rdy);
    end
    vecs++;
    if (clrs != 0) begin
      errs++;
      $display("FAIL b2b_single_clr got %0d extra clr pulses want 0", clrs);
    end
    release_tx();
  endtask

  task automatic test_reset_mid_move();
    int trmts;
    cmd = 16'h4104; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    ir_pulse(); ir_pulse(); ir_pulse();
    vecs++;
    if (!(moving === 1'b1 && dsrd_hdg === 8'h10)) begin
      errs++;
      $display("FAIL rstmv_pre got mov=%b hdg=%h want 1 10", moving, dsrd_hdg);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({clr_cmd_rdy, trmt, strt_cal, moving, resp, dsrd_hdg} !== 20'h0) begin
      errs++;
      $display("FAIL rstmv_async got clr=%b trmt=%b strt=%b mov=%b resp=%h hdg=%h want all 0",
               clr_cmd_rdy, trmt, strt_cal, moving, resp, dsrd_hdg);
    end
    tick(); tick();
    rst_n = 1'b1;
    trmts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      trmts += int'(trmt) + int'(moving);
    end
    vecs++;
    if (trmts != 0) begin
      errs++;
      $display("FAIL rstmv_no_resp got %0d trmt/moving cycles want 0", trmts);
    end
  endtask

  initial begin
    test_reset();
    test_cal();
    test_move();
    test_timeout();
    test_illegal_zero();
    test_back_to_back();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cmd_proc.md
# cmd_proc

Command execution stage that sits directly downstream of `UART_wrapper`: consumes each assembled 16-bit command (`cmd`/`cmd_rdy`), acknowledges it with `clr_cmd_rdy`, executes it (calibration or a square-counted move), then returns a one-byte response through the wrapper's transmit side (`trmt`/`resp`/`tx_done`). Only one command is in flight at a time; the next command is not accepted until the previous response has finished transmitting.

## Interface
- `MOVE_TMO`, default 24'd10_000_000: MOVING-state timeout in clocks, minimum 2.
- `clk`  in  1  system clock, all state on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd`  in  16  command word from UART_wrapper; valid while `cmd_rdy`=1
- `cmd_rdy`  in  1  level; held high by the wrapper until `clr_cmd_rdy`
- `clr_cmd_rdy`  out  1  one-cycle pulse, command accepted
- `trmt`  out  1  one-cycle pulse, start transmitting `resp`
- `resp`  out  8  response byte, stable from `trmt` until next accepted command
- `tx_done`  in  1  level from wrapper TX; cleared by it on `trmt`, set when byte sent
- `strt_cal`  out  1  one-cycle pulse, start calibration
- `cal_done`  in  1  calibration complete (synchronous)
- `cntrIR`  in  1  asynchronous line-crossing sensor, pulse per line crossed
- `moving`  out  1  high while a move executes
- `dsrd_hdg`  out  8  desired heading, loaded at MOVE accept, held afterwards

## Operation
- Opcode `cmd[15:12]`: 4'h2 CAL; 4'h4 MOVE (`cmd[11:4]` heading, `cmd[3:0]` squares); all others illegal.
- States: IDLE, CAL_WAIT, MOVING, RESP, WAIT_TX.
- IDLE, `cmd_rdy`=1 at edge N: latch opcode and operands; `clr_cmd_rdy`=1 for the cycle after N.
  - CAL: → CAL_WAIT, `strt_cal`=1 for the cycle after N.
  - MOVE, squares≠0: `dsrd_hdg`←`cmd[11:4]`, line counter←0, timeout counter←0, `moving`=1; → MOVING.
  - MOVE, squares=0: `dsrd_hdg` loaded, → RESP with `resp`=8'hA5.
  - Illegal: → RESP with `resp`=8'hEE; no other output changes.
- CAL_WAIT: stay until `cal_done`=1; then → RESP, `resp`=8'hA5. No timeout.
- MOVING: `cntrIR` passes a two-flop synchronizer then rising-edge detect; each detected edge increments a 5-bit line counter. Complete when counter == 2×squares (max 30): `moving`←0, → RESP, `resp`=8'hA5. Timeout counter increments every MOVING cycle; at MOVE_TMO−1 with no completion: `moving`←0, → RESP, `resp`=8'hEE. Completion and timeout in the same cycle: completion wins (8'hA5).
- RESP: exactly one cycle, `trmt`=1; → WAIT_TX.
- WAIT_TX: → IDLE when `tx_done`=1. `cmd_rdy` is ignored outside IDLE (the wrapper holds it).
- `cmd_rdy` already high on entry to IDLE is accepted on the next edge.

## Timing
- Reset (async, any state): state IDLE; `clr_cmd_rdy`, `trmt`, `strt_cal`, `moving` = 0; `resp`=8'h00; `dsrd_hdg`=8'h00; counters 0; synchronizer flops 0. Mid-move reset drops `moving` immediately; no response sent.
- All outputs registered; no combinational input→output path.
- Accept latency: `cmd_rdy` high before edge N → `clr_cmd_rdy`/`strt_cal`/`moving` high after edge N.
- `cntrIR` rising edge to counter increment: 3 clocks.
- Completion/timeout to `trmt`: `moving` falls at edge M, `trmt` high for cycle after M (RESP), WAIT_TX from edge M+1; `tx_done` is never sampled during the `trmt` cycle.
- Illegal/zero-square command: `trmt` two cycles after accept edge.
- `trmt`, `strt_cal`, `clr_cmd_rdy` never high more than one consecutive cycle.

## Test plan
- CAL: `cmd`=16'h2000, hold `cal_done`=0 for 50 clks then 1 → one `clr_cmd_rdy` and one `strt_cal` pulse, `trmt` after `cal_done`, `resp`=8'hA5, back to IDLE after `tx_done`.
- MOVE: `cmd`=16'h43F2, 4 `cntrIR` pulses → `dsrd_hdg`=8'h3F, `moving` high until 3 clks after 4th edge, `resp`=8'hA5.
- Timeout: MOVE_TMO=1000, `cmd`=16'h4013, 2 pulses only → `moving` falls after 1000 MOVING cycles, `resp`=8'hEE.
- Illegal/zero: `cmd`=16'h7000 → `resp`=8'hEE, `moving`/`strt_cal` never high; `cmd`=16'h4550 → `resp`=8'hA5, `dsrd_hdg`=8'h55, `moving` never high.
- Back-to-back: second `cmd_rdy` during WAIT_TX → not accepted until `tx_done`; then exactly one `clr_cmd_rdy`.
- Reset mid-MOVE (`cmd`=16'h4104, after 3 edges) → all outputs reset values immediately, no `trmt`.
